// File: rtl/ring_buffer_ctrl.sv
// Ring-buffer FIFO controller: write/read cursors over a BRAM with a
// 1-deep prefetched output stage that hides the BRAM's 1-cycle read latency.
// Optional build macro RING_BUFFER_CTRL_WATERMARK_EN adds AF_THRESH and a
// registered almost_full_out flag.
module ring_buffer_ctrl #(
   parameter int DEPTH     = 64,
`ifdef RING_BUFFER_CTRL_WATERMARK_EN
   parameter int AF_THRESH = DEPTH - 4,
`endif
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              flush_in,
   input  logic              wr_valid_in,
   output logic              wr_ready_out,
   output logic              wr_en_out,
   output logic [ADDR_W-1:0] wr_addr_out,
   output logic              rd_en_out,
   output logic [ADDR_W-1:0] rd_addr_out,
   output logic              rd_valid_out,
   input  logic              rd_ready_in,
   output logic [CNT_W-1:0]  count_out
`ifdef RING_BUFFER_CTRL_WATERMARK_EN
   ,
   output logic              almost_full_out
`endif
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  avail;
   logic              rd_valid;

   logic              push;
   logic              pop;
   logic              fetch;
   logic [CNT_W-1:0]  count_nxt;
   logic [CNT_W-1:0]  avail_nxt;
   logic              rd_valid_nxt;

   // Cursor step with wrap at DEPTH-1; DEPTH need not be a power of two.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
   endfunction

   // Handshakes; flush blocks both BRAM strobes. Full blocks writes even when
   // a pop happens in the same cycle (no write bypass).
   always_comb begin
      wr_ready_out = (count < FULL_CNT);
      push         = wr_valid_in & wr_ready_out & ~flush_in;
      pop          = rd_valid & rd_ready_in;
      fetch        = (avail != '0) & (~rd_valid | pop) & ~flush_in;
   end

   // Next occupancy, unfetched-word count and output-stage valid.
   always_comb begin
      count_nxt    = '0;
      avail_nxt    = '0;
      rd_valid_nxt = 1'b0;
      if (!flush_in) begin
         count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
         avail_nxt    = avail + CNT_W'(push) - CNT_W'(fetch);
         rd_valid_nxt = fetch | (rd_valid & ~pop);
      end
   end

   // State registers; flush returns everything to the reset state.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         avail    <= '0;
         rd_valid <= 1'b0;
      end else begin
         count    <= count_nxt;
         avail    <= avail_nxt;
         rd_valid <= rd_valid_nxt;
         if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)  wr_ptr <= next_addr(wr_ptr);
            if (fetch) rd_ptr <= next_addr(rd_ptr);
         end
      end
   end

`ifdef RING_BUFFER_CTRL_WATERMARK_EN
   // Watermark tracks the occupancy that will be visible next cycle.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         almost_full_out <= 1'b0;
      else if (flush_in)
         almost_full_out <= 1'b0;
      else
         almost_full_out <= (int'(count_nxt) >= AF_THRESH);
   end
`endif

   // Output mapping.
   always_comb begin
      wr_en_out    = push;
      wr_addr_out  = wr_ptr;
      rd_en_out    = fetch;
      rd_addr_out  = rd_ptr;
      rd_valid_out = rd_valid;
      count_out    = count;
   end

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// Bench for ring_buffer_ctrl (DEPTH=11): vector table, directed corner cases
// and randomized traffic against a queue-based reference model with a BRAM
// model for data-order scoreboarding.
module tb_ring_buffer_ctrl;
   localparam int D  = 11;
   localparam int AF = 7;
   localparam int AW = $clog2(D);
   localparam int CW = $clog2(D + 1);

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          flush_in;
   logic          wr_valid_in;
   logic          wr_ready_out;
   logic          wr_en_out;
   logic [AW-1:0] wr_addr_out;
   logic          rd_en_out;
   logic [AW-1:0] rd_addr_out;
   logic          rd_valid_out;
   logic          rd_ready_in;
   logic [CW-1:0] count_out;
`ifdef RING_BUFFER_CTRL_WATERMARK_EN
   logic          almost_full_out;
`endif

   ring_buffer_ctrl #(
      .DEPTH(D)
`ifdef RING_BUFFER_CTRL_WATERMARK_EN
      , .AF_THRESH(AF)
`endif
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .flush_in(flush_in),
      .wr_valid_in(wr_valid_in),
      .wr_ready_out(wr_ready_out),
      .wr_en_out(wr_en_out),
      .wr_addr_out(wr_addr_out),
      .rd_en_out(rd_en_out),
      .rd_addr_out(rd_addr_out),
      .rd_valid_out(rd_valid_out),
      .rd_ready_in(rd_ready_in),
      .count_out(count_out)
`ifdef RING_BUFFER_CTRL_WATERMARK_EN
      , .almost_full_out(almost_full_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   // BRAM model driven by the controller's strobes.
   logic [31:0] mem [0:D-1];
   logic [31:0] bram_q;
   logic [31:0] wdata;
   always @(posedge clk_in) begin
      if (wr_en_out) mem[wr_addr_out] <= wdata;
      if (rd_en_out) bram_q <= mem[rd_addr_out];
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: FIFO contents, staged-head flag, push/fetch positions.
   int q[$];
   bit m_rv;
   int m_wp, m_rp;
   bit m_af;

   typedef struct {
      bit f; bit wv; bit rr;
      bit e_wen; bit e_ren; bit e_rv;
      int e_cnt; int e_wa; int e_ra; bit e_rdy;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_rv = 0; m_wp = 0; m_rp = 0; m_af = 0;
   endtask

   task automatic do_reset();
      rst_in = 1'b1; flush_in = 1'b0; wr_valid_in = 1'b0; rd_ready_in = 1'b0;
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      model_reset();
   endtask

   // One clock against the model; called at posedge+1.
   task automatic run_cycle(input bit f, input bit wv, input bit rr);
      bit e_rdy, e_push, e_pop, e_fetch;
      flush_in = f; wr_valid_in = wv; rd_ready_in = rr; wdata = $urandom;
      #3;
      e_rdy   = q.size() < D;
      e_push  = wv && e_rdy && !f;
      e_pop   = m_rv && rr;
      e_fetch = !f && (int'(q.size()) - int'(m_rv) > 0) && (!m_rv || e_pop);
      chk("wr_ready", int'(wr_ready_out), int'(e_rdy));
      chk("wr_en",    int'(wr_en_out),    int'(e_push));
      chk("rd_en",    int'(rd_en_out),    int'(e_fetch));
      chk("rd_valid", int'(rd_valid_out), int'(m_rv));
      chk("count",    int'(count_out),    q.size());
      chk("wr_addr",  int'(wr_addr_out),  m_wp);
      chk("rd_addr",  int'(rd_addr_out),  m_rp);
`ifdef RING_BUFFER_CTRL_WATERMARK_EN
      chk("almost_full", int'(almost_full_out), int'(m_af));
`endif
      if (e_pop) chk("pop_data", int'(bram_q), q[0]);
      if (f) begin
         model_reset();
      end else begin
         if (e_pop)  void'(q.pop_front());
         if (e_push) q.push_back(int'(wdata));
         m_rv = e_fetch || (m_rv && !e_pop);
         if (e_push)  m_wp = (m_wp + 1) % D;
         if (e_fetch) m_rp = (m_rp + 1) % D;
         m_af = (q.size() >= AF);
      end
      @(posedge clk_in); #1;
   endtask

   task automatic apply_row(input int i, input vec_t v);
      flush_in = v.f; wr_valid_in = v.wv; rd_ready_in = v.rr; wdata = $urandom;
      #3;
      chk($sformatf("vec%0d_wr_en", i),    int'(wr_en_out),    int'(v.e_wen));
      chk($sformatf("vec%0d_rd_en", i),    int'(rd_en_out),    int'(v.e_ren));
      chk($sformatf("vec%0d_rd_valid", i), int'(rd_valid_out), int'(v.e_rv));
      chk($sformatf("vec%0d_count", i),    int'(count_out),    v.e_cnt);
      chk($sformatf("vec%0d_wr_addr", i),  int'(wr_addr_out),  v.e_wa);
      chk($sformatf("vec%0d_rd_addr", i),  int'(rd_addr_out),  v.e_ra);
      chk($sformatf("vec%0d_wr_ready", i), int'(wr_ready_out), int'(v.e_rdy));
      @(posedge clk_in); #1;
   endtask

   initial begin
      rst_in = 1'b1; flush_in = 1'b0; wr_valid_in = 1'b0; rd_ready_in = 1'b0;
      wdata = '0;

      //          f wv rr  wen ren rv  cnt wa ra rdy
      tbl[0]  = '{0, 0, 0,  0,  0,  0,  0,  0, 0, 1};
      tbl[1]  = '{0, 1, 0,  1,  0,  0,  0,  0, 0, 1};
      tbl[2]  = '{0, 0, 0,  0,  1,  0,  1,  1, 0, 1};
      tbl[3]  = '{0, 0, 0,  0,  0,  1,  1,  1, 1, 1};
      tbl[4]  = '{0, 0, 0,  0,  0,  1,  1,  1, 1, 1};
      tbl[5]  = '{0, 1, 1,  1,  0,  1,  1,  1, 1, 1};
      tbl[6]  = '{0, 0, 1,  0,  1,  0,  1,  2, 1, 1};
      tbl[7]  = '{0, 1, 1,  1,  0,  1,  1,  2, 2, 1};
      tbl[8]  = '{0, 1, 0,  1,  1,  0,  1,  3, 2, 1};
      tbl[9]  = '{1, 1, 1,  0,  0,  1,  2,  4, 3, 1};
      tbl[10] = '{0, 0, 0,  0,  0,  0,  0,  0, 0, 1};

      do_reset();
      for (int i = 0; i < 11; i++) apply_row(i, tbl[i]);

      // Fill to full, blocked push, push+pop while full, then push accepted.
      do_reset();
      for (int i = 0; i < D; i++) run_cycle(0, 1, 0);
      chk("full_count", int'(count_out), D);
      chk("full_ready", int'(wr_ready_out), 0);
      chk("full_wr_addr", int'(wr_addr_out), 0);
      chk("full_wr_en", int'(wr_en_out), 0);
      run_cycle(0, 1, 0);
      run_cycle(0, 1, 1);
      chk("after_pop_count", int'(count_out), D - 1);
      chk("after_pop_wr_en", int'(wr_en_out), 1);
      run_cycle(0, 1, 0);
      chk("refill_count", int'(count_out), D);

      // Continuous stream: count bounded, addresses wrap on both sides.
      do_reset();
      for (int i = 0; i < 30; i++) begin
         run_cycle(0, 1, 1);
         chk("stream_cnt_le2", int'(count_out <= 2), 1);
      end

      // Flush after partial fill with a push attempt in the flush cycle.
      do_reset();
      for (int i = 0; i < 5; i++) run_cycle(0, 1, 0);
      run_cycle(1, 1, 0);
      chk("flush_count", int'(count_out), 0);
      chk("flush_rd_valid", int'(rd_valid_out), 0);
      chk("flush_wr_addr", int'(wr_addr_out), 0);
      chk("flush_rd_addr", int'(rd_addr_out), 0);

`ifdef RING_BUFFER_CTRL_WATERMARK_EN
      do_reset();
      for (int i = 0; i < AF; i++) run_cycle(0, 1, 0);
      chk("af_count", int'(count_out), AF);
      chk("af_rise", int'(almost_full_out), 1);
      run_cycle(0, 0, 1);
      chk("af_fall_count", int'(count_out), AF - 1);
      chk("af_fall", int'(almost_full_out), 0);
`endif

      // Randomized traffic with varying pressure in phases.
      do_reset();
      for (int p = 0; p < 15; p++) begin
         int pw, pr;
         pw = $urandom_range(10, 95);
         pr = $urandom_range(10, 95);
         for (int c = 0; c < 200; c++)
            run_cycle($urandom_range(0, 199) == 0,
                      $urandom_range(0, 99) < pw,
                      $urandom_range(0, 99) < pr);
      end

      // Asynchronous reset in the middle of a burst.
      for (int i = 0; i < 8; i++) run_cycle(0, 1, i > 3);
      #2 rst_in = 1'b1;
      #1;
      chk("arst_count", int'(count_out), 0);
      chk("arst_rd_valid", int'(rd_valid_out), 0);
      chk("arst_wr_addr", int'(wr_addr_out), 0);
      chk("arst_rd_addr", int'(rd_addr_out), 0);
      chk("arst_wr_ready", int'(wr_ready_out), 1);
      chk("arst_rd_en", int'(rd_en_out), 0);
`ifdef RING_BUFFER_CTRL_WATERMARK_EN
      chk("arst_almost_full", int'(almost_full_out), 0);
`endif
      wr_valid_in = 1'b0; rd_ready_in = 1'b0;
      #1;
      chk("arst_wr_en", int'(wr_en_out), 0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      model_reset();
      run_cycle(0, 1, 0);
      run_cycle(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ring_buffer_ctrl.md
Name: ring_buffer_ctrl

Overview:
- Controller that sequences a pair of wrap-around address cursors (write and read) over a single-port-per-side BRAM, forming a FIFO.
- Issues BRAM write enables/addresses on a valid/ready producer side.
- Prefetches one entry into a 1-deep output stage on a valid/ready consumer side, absorbing the BRAM's 1-cycle read latency.
- Sits between pixel/memory producers and consumers wherever the design buffers streams in block RAM.

Parameters:
- DEPTH, 64, number of entries; any value ≥2, not required to be a power of two.
- ADDR_W, $clog2(DEPTH), width of BRAM address outputs.
- CNT_W, $clog2(DEPTH+1), width of occupancy count.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- flush_in  input  1  synchronous clear of all pointers and counts.
- wr_valid_in  input  1  producer has a word this cycle.
- wr_ready_out  output  1  controller accepts the word this cycle.
- wr_en_out  output  1  BRAM write enable (= wr_valid_in & wr_ready_out).
- wr_addr_out  output  ADDR_W  BRAM write address (write cursor).
- rd_en_out  output  1  BRAM read enable (fetch issued this cycle).
- rd_addr_out  output  ADDR_W  BRAM read address (fetch cursor).
- rd_valid_out  output  1  BRAM output holds a valid head word.
- rd_ready_in  input  1  consumer takes the head word this cycle.
- count_out  output  CNT_W  entries accepted and not yet popped, including the staged head.

Behaviour:
- Reset (async, rst_in=1): write cursor=0, fetch cursor=0, count=0, avail=0, rd_valid_out=0; hence wr_addr_out=0, rd_addr_out=0, wr_ready_out=1, wr_en_out=0, rd_en_out=0.
- Cursors: each advances by 1 on its enable; from DEPTH-1 it wraps to 0. No other values are ever produced.
- push = wr_valid_in & wr_ready_out. wr_ready_out = (count < DEPTH), combinational from registered count.
- avail = words written but not yet fetched (internal register).
- pop = rd_valid_out & rd_ready_in.
- fetch (rd_en_out) = (avail > 0) & (!rd_valid_out | pop). Combinational; rd_addr_out = fetch cursor.
- rd_valid_out next = fetch | (rd_valid_out & !pop). Data is valid at BRAM output one cycle after rd_en_out.
- count next = count + push − pop. Both together leave count unchanged.
- avail next = avail + push − fetch.
- Write-to-read latency: a word pushed in cycle t is fetchable at t+1 and rd_valid_out rises at t+2 if the stage was empty.
- Full: count==DEPTH. wr_ready_out=0, no write bypass even if pop occurs the same cycle. A push is possible the cycle after the pop.
- Empty: avail==0 suppresses rd_en_out. rd_valid_out may still be 1 for the staged word.
- Back-to-back: with rd_ready_in held high and avail>0, one pop per cycle (fetch and pop same cycle).
- flush_in=1: next state equals reset state and overrides push/pop/fetch in that cycle. wr_en_out and rd_en_out are forced 0 that cycle.
- rst_in asserted mid-burst: outputs return to reset values immediately (async). BRAM contents are don't-care.

Optional Feature:
- Macro: RING_BUFFER_CTRL_WATERMARK_EN.
- When defined:
  - Adds parameter AF_THRESH (default DEPTH-4).
  - Adds output almost_full_out (1), registered, = (count_next ≥ AF_THRESH). Reset value 0; cleared by flush.
- When undefined: neither the port nor the parameter exists; all other behaviour is identical.

Test Plan:
- Reset then idle, DEPTH=11 → wr_addr_out=0, rd_addr_out=0, wr_ready_out=1, rd_valid_out=0, count_out=0.
- Push 1 word at cycle t, rd_ready_in=0 → rd_en_out=1 at t+1 (rd_addr 0), rd_valid_out=1 from t+2 and held; count_out=1.
- Fill DEPTH=11 with rd_ready_in=0 → wr_ready_out=0 after 11th push, count_out=11, wr_addr_out wrapped to 0. A push attempted while full gives no wr_en_out. Push+pop in the same cycle while full → count_out=10, next push accepted.
- Continuous stream, wr_valid_in=1 and rd_ready_in=1 for 30 cycles, DEPTH=11 → one pop/cycle at steady state. Addresses wrap 10→0 on both sides. Popped order matches written order (scoreboard). count_out stays ≤2.
- Partial fill to 5, assert flush_in one cycle with wr_valid_in=1 → next cycle count_out=0, rd_valid_out=0, both addresses 0, no wr_en_out in the flush cycle.
- With RING_BUFFER_CTRL_WATERMARK_EN, DEPTH=11, AF_THRESH=7 → almost_full_out rises on the cycle count_out becomes 7. It falls when count_out drops to 6. Async rst_in mid-burst → all outputs at reset values within the same cycle.
